// File: rtl/axi_lite_responder_if.sv
// AXI4-Lite bus bundle between the capture-bridge initiator and the register responder.
interface axi_lite_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AXI_awaddr;
  logic                  AXI_awvalid;
  logic                  AXI_awready;
  logic [31:0]           AXI_wdata;
  logic [3:0]            AXI_wstrb;
  logic                  AXI_wvalid;
  logic                  AXI_wready;
  logic [1:0]            AXI_bresp;
  logic                  AXI_bvalid;
  logic                  AXI_bready;
  logic [ADDR_WIDTH-1:0] AXI_araddr;
  logic                  AXI_arvalid;
  logic                  AXI_arready;
  logic [31:0]           AXI_rdata;
  logic [1:0]            AXI_rresp;
  logic                  AXI_rvalid;
  logic                  AXI_rready;

  modport master (
    output AXI_awaddr, AXI_awvalid, AXI_wdata, AXI_wstrb, AXI_wvalid, AXI_bready,
           AXI_araddr, AXI_arvalid, AXI_rready,
    input  AXI_awready, AXI_wready, AXI_bresp, AXI_bvalid,
           AXI_arready, AXI_rdata, AXI_rresp, AXI_rvalid
  );

  modport slave (
    input  AXI_awaddr, AXI_awvalid, AXI_wdata, AXI_wstrb, AXI_wvalid, AXI_bready,
           AXI_araddr, AXI_arvalid, AXI_rready,
    output AXI_awready, AXI_wready, AXI_bresp, AXI_bvalid,
           AXI_arready, AXI_rdata, AXI_rresp, AXI_rvalid
  );
endinterface

// File: rtl/axi_lite_responder.sv
// AXI4-Lite register bank of NREGS x 32 bits with per-register write pulses.
// Define AXI_LITE_RESPONDER_SLVERR_EN to answer out-of-range accesses with SLVERR.
//
// state    | meaning
// W_IDLE   | waiting for AW and/or W
// W_HAVE_A | address latched, waiting for W
// W_HAVE_D | data/strobes latched, waiting for AW
// W_RESP   | write response pending (bvalid)
// R_IDLE   | waiting for AR
// R_RESP   | read data pending (rvalid)
module axi_lite_responder #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          NREGS       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                  AXI_CLK,
  input  logic                  RESET,
  axi_lite_responder_if.slave   axi,
  output logic [NREGS*32-1:0]   regs_out,
  output logic [NREGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_RESPONDER_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [1:0]       bresp_q;
  logic [31:0]      regs_q [NREGS];
  logic [NREGS-1:0] pulse_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  logic             aw_hs, w_hs, ar_hs;
  logic             latch_a, latch_d, do_wr, wr_ok;
  logic [IDX_W-1:0] wr_idx, ar_idx;
  logic [31:0]      wr_data, rd_word;
  logic [3:0]       wr_strb;
  logic             unused_addr_lsb;

  // Wide compares keep the decode correct for any ADDR_WIDTH / NREGS pairing.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {32'd0, idx} < {{IDX_W{1'b0}}, 32'(NREGS)};
  endfunction

  function automatic logic idx_hit(input logic [IDX_W-1:0] idx, input int i);
    return {32'd0, idx} == {{IDX_W{1'b0}}, 32'(i)};
  endfunction

  assign unused_addr_lsb = ^{axi.AXI_awaddr[1:0], axi.AXI_araddr[1:0]};

  assign axi.AXI_awready = !RESET && (w_state == W_IDLE || w_state == W_HAVE_D);
  assign axi.AXI_wready  = !RESET && (w_state == W_IDLE || w_state == W_HAVE_A);
  assign axi.AXI_bvalid  = (w_state == W_RESP);
  assign axi.AXI_bresp   = bresp_q;
  assign axi.AXI_arready = !RESET && (r_state == R_IDLE);
  assign axi.AXI_rvalid  = (r_state == R_RESP);
  assign axi.AXI_rdata   = rdata_q;
  assign axi.AXI_rresp   = rresp_q;
  assign reg_wr_pulse    = pulse_q;

  assign aw_hs  = axi.AXI_awvalid && axi.AXI_awready;
  assign w_hs   = axi.AXI_wvalid && axi.AXI_wready;
  assign ar_hs  = axi.AXI_arvalid && axi.AXI_arready;
  assign ar_idx = axi.AXI_araddr[ADDR_WIDTH-1:2];
  assign wr_ok  = in_range(wr_idx);

  always_comb begin
    w_state_nxt = w_state;
    latch_a     = 1'b0;
    latch_d     = 1'b0;
    do_wr       = 1'b0;
    wr_idx      = axi.AXI_awaddr[ADDR_WIDTH-1:2];
    wr_data     = axi.AXI_wdata;
    wr_strb     = axi.AXI_wstrb;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          do_wr       = 1'b1;
          w_state_nxt = W_RESP;
        end else if (aw_hs) begin
          latch_a     = 1'b1;
          w_state_nxt = W_HAVE_A;
        end else if (w_hs) begin
          latch_d     = 1'b1;
          w_state_nxt = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        wr_idx = aw_idx_q;
        if (w_hs) begin
          do_wr       = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_HAVE_D: begin
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        if (aw_hs) begin
          do_wr       = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (axi.AXI_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK or posedge RESET) begin
    if (RESET) begin
      w_state  <= W_IDLE;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      pulse_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      w_state <= w_state_nxt;
      pulse_q <= '0;
      if (latch_a) aw_idx_q <= wr_idx;
      if (latch_d) begin
        wdata_q <= wr_data;
        wstrb_q <= wr_strb;
      end
      if (do_wr) begin
        bresp_q <= wr_ok ? RESP_OKAY : OOR_RESP;
        for (int i = 0; i < NREGS; i++) begin
          if (wr_ok && idx_hit(wr_idx, i)) begin
            // Pulse fires even with all strobes low: the write itself is the event.
            pulse_q[i] <= 1'b1;
            for (int k = 0; k < 4; k++) begin
              if (wr_strb[k]) regs_q[i][8*k +: 8] <= wr_data[8*k +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_RESP;
      R_RESP:  if (axi.AXI_rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx_hit(ar_idx, i)) rd_word = regs_q[i];
    end
  end

  // Read data is captured from the pre-edge register value, so a same-edge write is not visible.
  always_ff @(posedge AXI_CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        rdata_q <= in_range(ar_idx) ? rd_word : 32'h0;
        rresp_q <= in_range(ar_idx) ? RESP_OKAY : OOR_RESP;
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NREGS; i++) regs_out[32*i +: 32] = regs_q[i];
  end

endmodule
